inv_shiftrow_pipe: RTL and testbench



---
 rtl/inv_shiftrow_pipe.sv | 114 +++++++++++
 tb/tb_inv_shiftrow_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/inv_shiftrow_pipe.sv
// AES decryption InvShiftRows stage behind a registered 2-entry valid/ready buffer.
// Optional sticky round-trip checker enabled by INV_SHIFTROW_SELFCHECK_EN (adds port chk_err).
module inv_shiftrow_pipe #(
  parameter int NB = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [32*NB-1:0] in_state,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [32*NB-1:0] out_state,
  output logic [1:0]       occupancy
`ifdef INV_SHIFTROW_SELFCHECK_EN
  ,
  output logic             chk_err
`endif
);
  localparam int W  = 32*NB;
  localparam int RW = 8*NB;
  // Right-rotation amounts in bits per row; row0 for NB=4 is rotl 8 == rotr 24.
  localparam int ROT0 = (NB == 4) ? 24 : 32;
  localparam int ROT1 = (NB == 4) ? 16 : 24;
  localparam int ROT2 = 8;

  if (!(NB == 4 || NB == 8)) begin : g_bad_nb
    $error("inv_shiftrow_pipe: NB must be 4 or 8");
  end

  function automatic logic [RW-1:0] rotr(input logic [RW-1:0] x, input int n);
    return (x >> n) | (x << (RW - n));
  endfunction

  function automatic logic [RW-1:0] rotl(input logic [RW-1:0] x, input int n);
    return (x << n) | (x >> (RW - n));
  endfunction

  function automatic logic [W-1:0] inv_rows(input logic [W-1:0] s);
    return {s[4*RW-1:3*RW], rotr(s[3*RW-1:2*RW], ROT2),
            rotr(s[2*RW-1:RW], ROT1), rotr(s[RW-1:0], ROT0)};
  endfunction

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_e;

  occ_e                  state_q, state_d;
  logic [1:0][W-1:0]     mem_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [W-1:0]          xf_state;
  logic                  push, pop;

  assign xf_state = inv_rows(in_state);
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        in_ready = rst_n;
        if (push) state_d = ONE;
      end
      ONE: begin
        in_ready  = rst_n;
        out_valid = 1'b1;
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL: begin
        out_valid = 1'b1;
        if (pop) state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Entries are written only on push, so don't-care input data never lands in storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) begin
        mem_q[wr_ptr_q] <= xf_state;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign out_state = mem_q[rd_ptr_q];
  assign occupancy = state_q;

`ifdef INV_SHIFTROW_SELFCHECK_EN
  function automatic logic [W-1:0] fwd_rows(input logic [W-1:0] s);
    return {s[4*RW-1:3*RW], rotl(s[3*RW-1:2*RW], ROT2),
            rotl(s[2*RW-1:RW], ROT1), rotl(s[RW-1:0], ROT0)};
  endfunction

  logic chk_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                                        chk_err_q <= 1'b0;
    else if (push && (fwd_rows(xf_state) != in_state)) chk_err_q <= 1'b1;
  end

  assign chk_err = chk_err_q;
`endif
endmodule

// File: tb/tb_inv_shiftrow_pipe.sv
// Directed bench for inv_shiftrow_pipe: NB=4 and NB=8 instances share handshake controls.
module tb_inv_shiftrow_pipe;
  logic         clk = 1'b0;
  logic         rst_n, in_valid, out_ready;
  logic [127:0] in4, out4;
  logic [255:0] in8, out8;
  logic         ir4, ir8, ov4, ov8;
  logic [1:0]   occ4, occ8;
`ifdef INV_SHIFTROW_SELFCHECK_EN
  logic         ce4, ce8;
`endif
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inv_shiftrow_pipe #(.NB(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .in_state(in4),
    .out_valid(ov4), .out_ready(out_ready), .out_state(out4), .occupancy(occ4)
`ifdef INV_SHIFTROW_SELFCHECK_EN
    , .chk_err(ce4)
`endif
  );

  inv_shiftrow_pipe #(.NB(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8), .in_state(in8),
    .out_valid(ov8), .out_ready(out_ready), .out_state(out8), .occupancy(occ8)
`ifdef INV_SHIFTROW_SELFCHECK_EN
    , .chk_err(ce8)
`endif
  );

  // Reference written straight from the byte-slice equations.
  function automatic logic [127:0] m4(input logic [127:0] i);
    return {i[127:96], i[71:64], i[95:72], i[47:32], i[63:48], i[23:0], i[31:24]};
  endfunction

  function automatic logic [255:0] m8(input logic [255:0] i);
    return {i[255:192], i[135:128], i[191:136], i[87:64], i[127:88], i[31:0], i[63:32]};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [127:0] in4;
    logic [255:0] in8;
    logic [127:0] exp4;
    logic [255:0] exp8;
  } vec_t;

  vec_t vecs[3];
  logic [127:0] a4, b4, c4, d4;
  logic [127:0] q4[$];
  logic [255:0] q8[$];
  int n_out;

  initial begin
    vecs[0] = '{128'h00112233_44556677_8899AABB_CCDDEEFF,
                256'h0011223344556677_8899AABBCCDDEEFF_0123456789ABCDEF_FEDCBA9876543210,
                128'h00112233_77445566_AABB8899_DDEEFFCC,
                256'h0011223344556677_FF8899AABBCCDDEE_ABCDEF0123456789_76543210FEDCBA98};
    vecs[1] = '{128'h00010203_04050607_08090A0B_0C0D0E0F,
                256'h0001020304050607_08090A0B0C0D0E0F_1011121314151617_18191A1B1C1D1E1F,
                128'h00010203_07040506_0A0B0809_0D0E0F0C,
                256'h0001020304050607_0F08090A0B0C0D0E_1516171011121314_1C1D1E1F18191A1B};
    vecs[2] = '{128'hFF000000_00FF0000_0000FF00_000000FF,
                256'h0,
                128'hFF000000_0000FF00_FF000000_0000FF00,
                256'h0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in4 = '0; in8 = '0;
    step(); step();
    chk("rst_occ", occ4, 0);
    chk("rst_ovalid", ov4, 0);
    chk("rst_ostate", out4, 0);
    chk("rst_iready_low", ir4, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_iready_rel", ir4, 1);

    // Single pushes with hand-computed results.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; out_ready = 1'b1; in4 = vecs[i].in4; in8 = vecs[i].in8;
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_ovalid", i), ov4, 1);
      chk($sformatf("vec%0d_occ", i), occ4, 1);
      chk($sformatf("vec%0d_out4", i), out4, vecs[i].exp4);
      chk($sformatf("vec%0d_out8", i), out8, vecs[i].exp8);
      step();
      chk($sformatf("vec%0d_drain", i), occ4, 0);
    end

    // Backpressure: A, B fill the buffer, C must wait.
    a4 = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
    b4 = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
    c4 = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
    out_ready = 1'b0; in_valid = 1'b1; in4 = a4;
    step();
    in4 = b4;
    step();
    chk("bp_occ_full", occ4, 2);
    chk("bp_iready", ir4, 0);
    in4 = c4;
    step();
    chk("bp_hold_occ", occ4, 2);
    chk("bp_hold_head", out4, m4(a4));
    chk("bp_hold_ovalid", ov4, 1);
    out_ready = 1'b1;
    step();
    chk("bp_pop_a_occ", occ4, 1);
    chk("bp_head_b", out4, m4(b4));
    step();
    chk("bp_pushpop_occ", occ4, 1);
    chk("bp_head_c", out4, m4(c4));
    in_valid = 1'b0;
    step();
    chk("bp_empty", ov4, 0);
    chk("bp_empty_occ", occ4, 0);

    // Streaming at full rate against a queue model.
    n_out = 0;
    for (int cyc = 0; cyc < 102; cyc++) begin
      in_valid = (cyc < 100);
      in4 = {$urandom, $urandom, $urandom, $urandom};
      in8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (cyc >= 1 && cyc <= 100) chk("str_ovalid", ov4, 1);
      if (ov4 && out_ready) begin
        if (q4.size() == 0) chk("str_underflow", 1, 0);
        else begin
          chk("str_out4", out4, q4.pop_front());
          chk("str_out8", out8, q8.pop_front());
          n_out++;
        end
      end
      if (in_valid && ir4) begin
        q4.push_back(m4(in4));
        q8.push_back(m8(in8));
      end
      step();
    end
    in_valid = 1'b0;
    chk("str_count", n_out, 100);

    // Reset while full discards both entries.
    d4 = 128'hD0D1D2D3_D4D5D6D7_D8D9DADB_DCDDDEDF;
    out_ready = 1'b0; in_valid = 1'b1; in4 = a4;
    step();
    in4 = b4;
    step();
    chk("mr_full", occ4, 2);
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    chk("mr_ovalid", ov4, 0);
    chk("mr_occ", occ4, 0);
    chk("mr_ostate", out4, 0);
    chk("mr_iready_low", ir4, 0);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    chk("mr_iready_rel", ir4, 1);
    step();
    chk("mr_no_ghost", ov4, 0);
    in_valid = 1'b1; in4 = d4;
    step();
    in_valid = 1'b0;
    chk("mr_new_head", out4, m4(d4));
    step();

`ifdef INV_SHIFTROW_SELFCHECK_EN
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in4 = {$urandom, $urandom, $urandom, $urandom};
      in8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      step();
    end
    in_valid = 1'b0;
    chk("sc_clean4", ce4, 0);
    chk("sc_clean8", ce8, 0);
    // Corrupt row2 of the transformed value for one push.
    in4 = a4; in_valid = 1'b1;
    force dut4.xf_state = m4(a4) ^ {32'h0, 32'h0000_00FF, 64'h0};
    step();
    release dut4.xf_state;
    in4 = b4;
    chk("sc_set", ce4, 1);
    chk("sc_other_clean", ce8, 0);
    step();
    in_valid = 1'b0;
    step();
    chk("sc_sticky", ce4, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("sc_rst_clr", ce4, 0);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
